alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Command-side initiator for the 8-bit ALU operand/control interface.
- Accepts one operation per valid/ready handshake (A, B, opcode, flag select).
- Drives the ALU's shared operand bus and control lines in the fixed order: load A with enable, present B, apply control, wait for settle.
- Captures result/flag/overflow into a one-entry response register; optional sweep mode runs all 8 opcodes on one operand pair.

Parameters:
- SETTLE_CYCLES, 1: cycles control is held before the ALU outputs are sampled; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_a  input  8  operand A
- cmd_b  input  8  operand B
- cmd_op  input  3  ALU opcode (ignored when cmd_sweep=1)
- cmd_flagsel  input  2  flag-control select
- cmd_sweep  input  1  run opcodes 0..7 in order
- alu_in  output  8  ALU operand bus
- alu_en_a  output  1  ALU operand-A load enable
- alu_ctrl  output  3  ALU opcode
- alu_flagctrl  output  2  ALU flag-control select
- alu_result  input  14  ALU result
- alu_flag  input  1  ALU selected flag
- alu_overflow  input  1  ALU overflow
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_result  output  14  captured result
- rsp_flag  output  1  captured flag
- rsp_overflow  output  1  captured overflow
- rsp_op  output  3  opcode that produced this response
- rsp_last  output  1  final response of the command
- busy  output  1  state != IDLE

Behaviour:
Clock, reset and outputs:
- Single clock domain; reset is asynchronous and active-low (rst_n); all state is in flops.
- Every output is registered except cmd_ready and busy, which decode the state.
- Reset values: state IDLE; alu_in 0; alu_en_a 0; alu_ctrl 0; alu_flagctrl 0; rsp_* 0; rsp_valid 0.

States:
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch a, b, flagsel and sweep; latch op (0 if sweep). Next state LOAD_A.
- LOAD_A (1 cycle): alu_in=a, alu_en_a=1. Next state LOAD_B.
- LOAD_B (1 cycle): alu_in=b, alu_en_a=0. Next state EXEC.
- EXEC (SETTLE_CYCLES cycles, 4-bit down-counter): alu_ctrl=op, alu_flagctrl=flagsel, alu_in held at b, alu_en_a=0. On the last cycle, sample alu_result/flag/overflow into rsp_*; set rsp_op=op and rsp_last=(!sweep | op==7); set rsp_valid=1. Next state RESP.
- RESP: hold the response until rsp_valid&rsp_ready, then clear rsp_valid on that edge.
  - If sweep and op!=7: op<=op+1, go to EXEC (A is not reloaded; B stays on alu_in).
  - Otherwise go to IDLE.

Latency (command handshake edge = cycle 0):
- alu_en_a is high during cycle 1.
- rsp_valid rises at cycle 3+SETTLE_CYCLES; 4 at default.
- With rsp_ready tied high, sweep responses are spaced SETTLE_CYCLES+1 cycles apart.

Boundary conditions:
- rsp_ready high in the cycle rsp_valid rises: handshake completes on that edge. There is no zero-cycle bypass.
- cmd_valid while busy: ignored, because cmd_ready=0; the command is not lost to the producer.
- Back-to-back commands: the next handshake is possible in the first IDLE cycle after the last response handshake.
- Sweep opcode counter stops at 7 and never wraps.
- alu_ctrl and alu_flagctrl hold their last values in IDLE; alu_in returns to 0 in IDLE.
- rst_n low mid-operation: immediate return to reset values, alu_en_a drops asynchronously, any pending response is discarded.

Decomposition:
- Shared package alu_pkg:
  - opcode width constant (3) and flag-select width constant (2);
  - result width constant (14);
  - state enum {IDLE, LOAD_A, LOAD_B, EXEC, RESP}.
- No sub-module needed; optionally split out alu_rsp_reg (the one-entry valid/ready holding register).

Test Plan:
- Reset: rst_n=0 -> all outputs 0, cmd_ready=1, busy=0.
- Single op, A=128, B=218, op=3, flagsel=2, rsp_ready=1, ALU stub result=14'h1ABC, flag=1, ovf=0:
  - alu_in=128 with en_a=1 at cycle 1;
  - alu_in=218 at cycle 2;
  - alu_ctrl=3 at cycle 3;
  - rsp_valid at cycle 4 with result 14'h1ABC, flag 1, rsp_op 3, rsp_last 1.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_* stable, cmd_ready=0, second cmd_valid ignored; rsp_ready=1 -> IDLE next cycle, then the second command is accepted.
- Sweep, A=128, B=218, stub result={11'b0,alu_ctrl}: exactly 8 responses with rsp_op 0..7 and result 0..7; en_a pulses once; rsp_last only on op 7.
- SETTLE_CYCLES=3: rsp_valid at cycle 6; a result change in the first EXEC cycle is not captured, the value present in the third EXEC cycle is.
- rst_n pulsed during EXEC: alu_en_a=0 and rsp_valid=0 immediately; the next command completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, FSM state encoding and response record for the ALU operand sequencer.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam int FLAG_W = 2;
  localparam int RES_W  = 14;
  localparam int CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_LAST = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    EXEC,
    RESP
  } state_t;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic             flag;
    logic             overflow;
    logic [OP_W-1:0]  op;
    logic             last;
  } rsp_t;

endpackage

// File: rtl/alu_op_sequencer_rsp.sv
// One-entry valid/ready holding register for captured ALU responses.
module alu_op_sequencer_rsp
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  rsp_t data_i,
  input  logic ready_i,
  output logic valid_o,
  output rsp_t data_o
);

  logic valid_q;
  rsp_t data_q;

  // A load always wins; the FSM never loads while a response is still held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side sequencer driving the 8-bit ALU operand bus and control lines.
//  state  | meaning
//  IDLE   | cmd_ready high, bus parked at 0
//  LOAD_A | operand A on bus with load enable
//  LOAD_B | operand B on bus
//  EXEC   | control applied, settle countdown, sample on terminal count
//  RESP   | response held until consumer handshake
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [FLAG_W-1:0] cmd_flagsel,
  input  logic              cmd_sweep,
  output logic [DATA_W-1:0] alu_in,
  output logic              alu_en_a,
  output logic [OP_W-1:0]   alu_ctrl,
  output logic [FLAG_W-1:0] alu_flagctrl,
  input  logic [RES_W-1:0]  alu_result,
  input  logic              alu_flag,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_flag,
  output logic              rsp_overflow,
  output logic [OP_W-1:0]   rsp_op,
  output logic              rsp_last,
  output logic              busy
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [FLAG_W-1:0] flagsel_q, flagsel_d;
  logic              sweep_q, sweep_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_in_q, alu_in_d;
  logic              en_a_q, en_a_d;
  logic [OP_W-1:0]   ctrl_q, ctrl_d;
  logic [FLAG_W-1:0] flagctrl_q, flagctrl_d;

  logic rsp_load;
  rsp_t rsp_d;
  rsp_t rsp_q;
  logic rsp_hs;

  assign rsp_hs = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      b_q        <= '0;
      op_q       <= '0;
      flagsel_q  <= '0;
      sweep_q    <= 1'b0;
      cnt_q      <= '0;
      alu_in_q   <= '0;
      en_a_q     <= 1'b0;
      ctrl_q     <= '0;
      flagctrl_q <= '0;
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      op_q       <= op_d;
      flagsel_q  <= flagsel_d;
      sweep_q    <= sweep_d;
      cnt_q      <= cnt_d;
      alu_in_q   <= alu_in_d;
      en_a_q     <= en_a_d;
      ctrl_q     <= ctrl_d;
      flagctrl_q <= flagctrl_d;
    end
  end

  // Bus/control registers are loaded alongside the state they belong to,
  // so each output is valid for the whole cycle its state is active.
  always_comb begin
    state_d    = state_q;
    b_d        = b_q;
    op_d       = op_q;
    flagsel_d  = flagsel_q;
    sweep_d    = sweep_q;
    cnt_d      = cnt_q;
    alu_in_d   = alu_in_q;
    en_a_d     = 1'b0;
    ctrl_d     = ctrl_q;
    flagctrl_d = flagctrl_q;
    rsp_load   = 1'b0;
    rsp_d      = '{result:   alu_result,
                   flag:     alu_flag,
                   overflow: alu_overflow,
                   op:       op_q,
                   last:     (!sweep_q) || (op_q == OP_LAST)};

    unique case (state_q)
      IDLE: begin
        alu_in_d = '0;
        if (cmd_valid) begin
          b_d       = cmd_b;
          flagsel_d = cmd_flagsel;
          sweep_d   = cmd_sweep;
          op_d      = cmd_sweep ? '0 : cmd_op;
          alu_in_d  = cmd_a;
          en_a_d    = 1'b1;
          state_d   = LOAD_A;
        end
      end
      LOAD_A: begin
        alu_in_d = b_q;
        state_d  = LOAD_B;
      end
      LOAD_B: begin
        ctrl_d     = op_q;
        flagctrl_d = flagsel_q;
        cnt_d      = SETTLE_LOAD;
        state_d    = EXEC;
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_load = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          if (sweep_q && (op_q != OP_LAST)) begin
            op_d    = op_q + 3'd1;
            ctrl_d  = op_q + 3'd1;
            cnt_d   = SETTLE_LOAD;
            state_d = EXEC;
          end else begin
            alu_in_d = '0;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        alu_in_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  alu_op_sequencer_rsp u_rsp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (rsp_load),
    .data_i  (rsp_d),
    .ready_i (rsp_ready),
    .valid_o (rsp_valid),
    .data_o  (rsp_q)
  );

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign alu_in       = alu_in_q;
  assign alu_en_a     = en_a_q;
  assign alu_ctrl     = ctrl_q;
  assign alu_flagctrl = flagctrl_q;
  assign rsp_result   = rsp_q.result;
  assign rsp_flag     = rsp_q.flag;
  assign rsp_overflow = rsp_q.overflow;
  assign rsp_op       = rsp_q.op;
  assign rsp_last     = rsp_q.last;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: default settle instance plus a SETTLE_CYCLES=3 instance.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_valid3;
  logic [7:0]  cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_flagsel;
  logic        cmd_sweep;
  logic        rsp_ready;
  logic        alu_flag, alu_overflow;
  logic [13:0] fixed_result, alu_result3;
  logic        stub_ctrl_mode;
  logic [13:0] alu_result;

  logic        cmd_ready, alu_en_a, rsp_valid, rsp_flag, rsp_overflow, rsp_last, busy;
  logic [7:0]  alu_in;
  logic [2:0]  alu_ctrl, rsp_op;
  logic [1:0]  alu_flagctrl;
  logic [13:0] rsp_result;

  logic        cmd_ready3, alu_en_a3, rsp_valid3, rsp_flag3, rsp_overflow3, rsp_last3, busy3;
  logic [7:0]  alu_in3;
  logic [2:0]  alu_ctrl3, rsp_op3;
  logic [1:0]  alu_flagctrl3;
  logic [13:0] rsp_result3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign alu_result = stub_ctrl_mode ? {11'b0, alu_ctrl} : fixed_result;

  alu_op_sequencer #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_flagsel(cmd_flagsel),
    .cmd_sweep(cmd_sweep), .alu_in(alu_in), .alu_en_a(alu_en_a), .alu_ctrl(alu_ctrl),
    .alu_flagctrl(alu_flagctrl), .alu_result(alu_result), .alu_flag(alu_flag),
    .alu_overflow(alu_overflow), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flag(rsp_flag), .rsp_overflow(rsp_overflow),
    .rsp_op(rsp_op), .rsp_last(rsp_last), .busy(busy)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_flagsel(cmd_flagsel),
    .cmd_sweep(cmd_sweep), .alu_in(alu_in3), .alu_en_a(alu_en_a3), .alu_ctrl(alu_ctrl3),
    .alu_flagctrl(alu_flagctrl3), .alu_result(alu_result3), .alu_flag(alu_flag),
    .alu_overflow(alu_overflow), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result3), .rsp_flag(rsp_flag3), .rsp_overflow(rsp_overflow3),
    .rsp_op(rsp_op3), .rsp_last(rsp_last3), .busy(busy3)
  );

  // Cycle n of a command is the period right after the n-th edge following the handshake edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cmd_valid = 0; cmd_valid3 = 0; cmd_a = 0; cmd_b = 0; cmd_op = 0; cmd_flagsel = 0;
    cmd_sweep = 0; rsp_ready = 0; alu_flag = 0; alu_overflow = 0; fixed_result = 0;
    alu_result3 = 0; stub_ctrl_mode = 0;
    rst_n = 0;
    #3;
    checks++;
    if (alu_in !== 8'd0 || alu_en_a !== 1'b0 || alu_ctrl !== 3'd0 || alu_flagctrl !== 2'd0) begin
      errors++;
      $display("FAIL reset_alu_outs: got in=%0d en=%0b ctrl=%0d fc=%0d, expected all 0",
               alu_in, alu_en_a, alu_ctrl, alu_flagctrl);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 14'd0 || rsp_flag !== 1'b0 ||
        rsp_overflow !== 1'b0 || rsp_op !== 3'd0 || rsp_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: got v=%0b res=%0h f=%0b o=%0b op=%0d last=%0b, expected all 0",
               rsp_valid, rsp_result, rsp_flag, rsp_overflow, rsp_op, rsp_last);
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_busy: got ready=%0b busy=%0b, expected ready=1 busy=0",
               cmd_ready, busy);
    end
    step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic test_single();
    cmd_a = 8'd128; cmd_b = 8'd218; cmd_op = 3'd3; cmd_flagsel = 2'd2; cmd_sweep = 0;
    rsp_ready = 1; fixed_result = 14'h1ABC; alu_flag = 1; alu_overflow = 0; stub_ctrl_mode = 0;
    cmd_valid = 1;
    step();
    cmd_valid = 0;
    checks++;
    if (alu_in !== 8'd128 || alu_en_a !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_cycle1: got in=%0d en=%0b busy=%0b ready=%0b, expected 128 1 1 0",
               alu_in, alu_en_a, busy, cmd_ready);
    end
    step();
    checks++;
    if (alu_in !== 8'd218 || alu_en_a !== 1'b0) begin
      errors++;
      $display("FAIL single_cycle2: got in=%0d en=%0b, expected 218 0", alu_in, alu_en_a);
    end
    step();
    checks++;
    if (alu_ctrl !== 3'd3 || alu_flagctrl !== 2'd2 || alu_in !== 8'd218 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_cycle3: got ctrl=%0d fc=%0d in=%0d v=%0b, expected 3 2 218 0",
               alu_ctrl, alu_flagctrl, alu_in, rsp_valid);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 14'h1ABC || rsp_flag !== 1'b1 ||
        rsp_overflow !== 1'b0 || rsp_op !== 3'd3 || rsp_last !== 1'b1) begin
      errors++;
      $display("FAIL single_rsp: got v=%0b res=%0h f=%0b o=%0b op=%0d last=%0b, expected 1 1abc 1 0 3 1",
               rsp_valid, rsp_result, rsp_flag, rsp_overflow, rsp_op, rsp_last);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_in !== 8'd0 || alu_ctrl !== 3'd3 ||
        alu_flagctrl !== 2'd2) begin
      errors++;
      $display("FAIL single_idle: got v=%0b ready=%0b in=%0d ctrl=%0d fc=%0d, expected 0 1 0 3 2",
               rsp_valid, cmd_ready, alu_in, alu_ctrl, alu_flagctrl);
    end
  endtask

  task automatic test_backpressure();
    cmd_a = 8'd5; cmd_b = 8'd9; cmd_op = 3'd1; cmd_flagsel = 2'd1; cmd_sweep = 0;
    rsp_ready = 0; fixed_result = 14'h0123; alu_flag = 0; alu_overflow = 1;
    cmd_valid = 1;
    step();
    cmd_valid = 0;
    step(); step(); step();
    cmd_a = 8'd7; cmd_b = 8'd3; cmd_op = 3'd2; cmd_flagsel = 2'd3;
    fixed_result = 14'h0456; alu_overflow = 0; alu_flag = 1;
    cmd_valid = 1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 14'h0123 || rsp_overflow !== 1'b1 ||
          rsp_op !== 3'd1 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%0b res=%0h o=%0b op=%0d ready=%0b, expected 1 123 1 1 0",
                 i, rsp_valid, rsp_result, rsp_overflow, rsp_op, cmd_ready);
      end
      step();
    end
    rsp_ready = 1;
    step();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got v=%0b ready=%0b, expected 0 1", rsp_valid, cmd_ready);
    end
    step();
    cmd_valid = 0;
    checks++;
    if (alu_in !== 8'd7 || alu_en_a !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_accept: got in=%0d en=%0b, expected 7 1", alu_in, alu_en_a);
    end
    step(); step(); step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 14'h0456 || rsp_op !== 3'd2 || rsp_flag !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_rsp: got v=%0b res=%0h op=%0d f=%0b, expected 1 456 2 1",
               rsp_valid, rsp_result, rsp_op, rsp_flag);
    end
    step();
  endtask

  task automatic test_back_to_back();
    cmd_a = 8'd11; cmd_b = 8'd22; cmd_op = 3'd6; cmd_flagsel = 2'd0; cmd_sweep = 0;
    rsp_ready = 1; fixed_result = 14'h2001; cmd_valid = 1;
    step();
    step(); step(); step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 14'h2001 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_rsp: got v=%0b res=%0h ready=%0b, expected 1 2001 0",
               rsp_valid, rsp_result, cmd_ready);
    end
    cmd_a = 8'd33; fixed_result = 14'h2002;
    step();
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got ready=%0b v=%0b, expected 1 0", cmd_ready, rsp_valid);
    end
    step();
    cmd_valid = 0;
    checks++;
    if (alu_in !== 8'd33 || alu_en_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_accept: got in=%0d en=%0b, expected 33 1", alu_in, alu_en_a);
    end
    step(); step(); step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 14'h2002) begin
      errors++;
      $display("FAIL b2b_second_rsp: got v=%0b res=%0h, expected 1 2002", rsp_valid, rsp_result);
    end
    step();
  endtask

  task automatic test_sweep();
    int n_rsp;
    int en_pulses;
    int last_cyc;
    cmd_a = 8'd128; cmd_b = 8'd218; cmd_op = 3'd5; cmd_flagsel = 2'd1; cmd_sweep = 1;
    rsp_ready = 1; stub_ctrl_mode = 1; cmd_valid = 1;
    n_rsp = 0; en_pulses = 0; last_cyc = 0;
    step();
    cmd_valid = 0; cmd_sweep = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (alu_en_a === 1'b1) en_pulses++;
      if (rsp_valid === 1'b1) begin
        checks++;
        if (n_rsp >= 8) begin
          errors++;
          $display("FAIL sweep_extra: got response %0d at cycle %0d, expected only 8", n_rsp, cyc);
        end else if (rsp_op !== 3'(n_rsp) || rsp_result !== 14'(n_rsp) ||
                     rsp_last !== (n_rsp == 7) || alu_in !== 8'd218) begin
          errors++;
          $display("FAIL sweep_rsp[%0d]: got op=%0d res=%0d last=%0b in=%0d, expected %0d %0d %0b 218",
                   n_rsp, rsp_op, rsp_result, rsp_last, alu_in, n_rsp, n_rsp, (n_rsp == 7));
        end
        checks++;
        if ((n_rsp == 0 && cyc != 4) || (n_rsp > 0 && cyc - last_cyc != 2)) begin
          errors++;
          $display("FAIL sweep_timing[%0d]: got cycle %0d (previous %0d), expected 4 then spacing 2",
                   n_rsp, cyc, last_cyc);
        end
        last_cyc = cyc;
        n_rsp++;
      end
      step();
    end
    checks++;
    if (n_rsp != 8 || en_pulses != 1) begin
      errors++;
      $display("FAIL sweep_count: got rsp=%0d en_pulses=%0d, expected 8 1", n_rsp, en_pulses);
    end
    checks++;
    if (busy !== 1'b0 || alu_in !== 8'd0 || alu_ctrl !== 3'd7) begin
      errors++;
      $display("FAIL sweep_end: got busy=%0b in=%0d ctrl=%0d, expected 0 0 7", busy, alu_in, alu_ctrl);
    end
    stub_ctrl_mode = 0;
  endtask

  task automatic test_settle3();
    cmd_a = 8'd1; cmd_b = 8'd2; cmd_op = 3'd4; cmd_flagsel = 2'd3; cmd_sweep = 0;
    rsp_ready = 1; alu_result3 = 14'h0000; cmd_valid3 = 1;
    step();
    cmd_valid3 = 0;
    step();
    step();
    alu_result3 = 14'h0111;
    checks++;
    if (alu_ctrl3 !== 3'd4 || rsp_valid3 !== 1'b0) begin
      errors++;
      $display("FAIL s3_exec_start: got ctrl=%0d v=%0b, expected 4 0", alu_ctrl3, rsp_valid3);
    end
    step();
    alu_result3 = 14'h0222;
    step();
    alu_result3 = 14'h0333;
    checks++;
    if (rsp_valid3 !== 1'b0) begin
      errors++;
      $display("FAIL s3_early: got v=%0b at cycle 5, expected 0", rsp_valid3);
    end
    step();
    checks++;
    if (rsp_valid3 !== 1'b1 || rsp_result3 !== 14'h0333 || rsp_op3 !== 3'd4 || rsp_last3 !== 1'b1) begin
      errors++;
      $display("FAIL s3_rsp: got v=%0b res=%0h op=%0d last=%0b, expected 1 333 4 1",
               rsp_valid3, rsp_result3, rsp_op3, rsp_last3);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int seen;
    cmd_a = 8'd9; cmd_b = 8'd10; cmd_op = 3'd6; cmd_flagsel = 2'd1; cmd_sweep = 0;
    rsp_ready = 1; fixed_result = 14'h0777; alu_flag = 0; alu_overflow = 1; cmd_valid = 1;
    step();
    cmd_valid = 0;
    #1;
    rst_n = 0;
    #1;
    checks++;
    if (alu_en_a !== 1'b0 || alu_in !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_load_a: got en=%0b in=%0d busy=%0b, expected 0 0 0", alu_en_a, alu_in, busy);
    end
    step();
    rst_n = 1;
    cmd_valid = 1;
    step();
    cmd_valid = 0;
    step(); step();
    rst_n = 0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || alu_ctrl !== 3'd0 || alu_flagctrl !== 2'd0 || busy !== 1'b0 ||
        alu_en_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_exec: got v=%0b ctrl=%0d fc=%0d busy=%0b en=%0b, expected 0 0 0 0 0",
               rsp_valid, alu_ctrl, alu_flagctrl, busy, alu_en_a);
    end
    step();
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid === 1'b1) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_discard: got %0d response cycles after reset, expected 0", seen);
    end
    cmd_valid = 1;
    step();
    cmd_valid = 0;
    step(); step(); step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 14'h0777 || rsp_op !== 3'd6 || rsp_overflow !== 1'b1) begin
      errors++;
      $display("FAIL rst_recover: got v=%0b res=%0h op=%0d o=%0b, expected 1 777 6 1",
               rsp_valid, rsp_result, rsp_op, rsp_overflow);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_sweep();
    test_settle3();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
